// File: rtl/rv32_pkg.sv
// rv32_pkg: opcode/funct3 constants, FSM and ALU enums, and the ALU itself
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {FETCH, EXECUTE, MEM_WAIT, HALT} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    function automatic alu_op_t alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_regfile.sv
// rv32_regfile: NUM_REGS x 32 register file, two async reads, one sync write, debug read
module rv32_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    localparam int AW = $clog2(NUM_REGS);

    logic [31:0] r [NUM_REGS];

    // indices past the implemented set read zero; r[0] is never written
    function automatic logic [31:0] rd(input logic [4:0] i);
        return (NUM_REGS == 32 || !i[4]) ? r[i[AW-1:0]] : '0;
    endfunction

    assign rd1      = rd(ra1);
    assign rd2      = rd(ra2);
    assign dbg_data = rd(dbg_sel);

    always_ff @(posedge clk) begin
        if (rst)
            for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
        else if (we && wa != 5'd0 && (NUM_REGS == 32 || !wa[4]))
            r[wa[AW-1:0]] <= wd;
    end

endmodule

// File: rtl/rv32_core.sv
// rv32_core: multi-cycle RV32I core (FETCH/EXECUTE/MEM_WAIT/HALT) with fixed-latency memory
module rv32_core import rv32_pkg::*; #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          NUM_REGS    = 32,
    parameter int          MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_data,
    output logic [31:0] read_address,
    output logic        write_mem,
    output logic [2:0]  funct3,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic        halted,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    state_t      state, state_nx;
    logic [31:0] pc, ir, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] ea_ld, alu_y, npc, ex_wd, ld_val, wd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [1:0]  cnt;
    logic        last, alt, br, is_load, is_store, is_jalr, ex_we, we;

    assign op    = ir[6:0];
    assign f3    = ir[14:12];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign last  = cnt == 2'(MEM_LATENCY - 1);

    rv32_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
        .clk(clk), .rst(rst), .ra1(ir[19:15]), .ra2(ir[24:20]), .rd1(rs1), .rd2(rs2),
        .we(we), .wa(ir[11:7]), .wd(wd), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    assign is_load  = op == OP_LOAD && f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    assign is_store = op == OP_STORE && f3 inside {F3_B, F3_H, F3_W};
    assign is_jalr  = op == OP_JALR && f3 == 3'b000;
    // ir[30] is an immediate bit for every OP-IMM except the right shifts
    assign alt      = (op == OP_OP || f3 == F3_SR) && ir[30];
    assign alu_y    = alu(alu_dec(f3, alt), rs1, op == OP_OP ? rs2 : imm_i);
    assign ea_ld    = rs1 + imm_i;

    assign br = f3 == F3_BEQ  ? rs1 == rs2 :
                f3 == F3_BNE  ? rs1 != rs2 :
                f3 == F3_BLT  ? $signed(rs1) <  $signed(rs2) :
                f3 == F3_BGE  ? $signed(rs1) >= $signed(rs2) :
                f3 == F3_BLTU ? rs1 <  rs2 :
                f3 == F3_BGEU ? rs1 >= rs2 : 1'b0;

    assign npc = op == OP_JAL              ? pc + imm_j :
                 is_jalr                   ? ea_ld & ~32'd1 :
                 (op == OP_BRANCH && br)   ? pc + imm_b : pc + 32'd4;

    assign ex_we = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_IMM, OP_OP} || is_jalr;
    assign ex_wd = op == OP_LUI              ? imm_u :
                   op == OP_AUIPC            ? pc + imm_u :
                   (op == OP_JAL || is_jalr) ? pc + 32'd4 : alu_y;

    assign ld_val = f3 == F3_B  ? {{24{read_data[7]}}, read_data[7:0]} :
                    f3 == F3_H  ? {{16{read_data[15]}}, read_data[15:0]} :
                    f3 == F3_BU ? {24'b0, read_data[7:0]} :
                    f3 == F3_HU ? {16'b0, read_data[15:0]} : read_data;

    assign we = (state == EXECUTE && ex_we) || (state == MEM_WAIT && last);
    assign wd = state == MEM_WAIT ? ld_val : ex_wd;

    assign read_address  = state == MEM_WAIT ? ea_ld : pc;
    assign funct3        = (state == MEM_WAIT || write_mem) ? f3 : F3_W;
    assign write_mem     = state == EXECUTE && is_store;
    assign write_address = write_mem ? rs1 + imm_s : '0;
    assign write_data    = write_mem ? rs2 : '0;
    assign halted        = state == HALT;

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:    state_nx = !last ? FETCH : read_data == '0 ? HALT : EXECUTE;
            EXECUTE:  state_nx = is_load ? MEM_WAIT : FETCH;
            MEM_WAIT: state_nx = last ? FETCH : MEM_WAIT;
            default:  state_nx = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_PC;
            ir  <= '0;
            cnt <= '0;
        end else begin
            cnt <= ((state == FETCH || state == MEM_WAIT) && !last) ? cnt + 2'd1 : 2'd0;
            if (state == FETCH && last) ir <= read_data;
            if (state == EXECUTE) pc <= npc;
        end
    end

endmodule

// File: tb/tb_rv32_core.sv
// tb_rv32_core: directed program tables for three core configurations
module tb_rv32_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic [31:0] rd_a, rd_b, rd_c, ra_a, ra_b, ra_c;
    logic [31:0] wa_a, wa_b, wa_c, wd_a, wd_b, wd_c, dd_a, dd_b, dd_c;
    logic        wm_a, wm_b, wm_c, h_a, h_b, h_c;
    logic [2:0]  f3_a, f3_b, f3_c;
    logic [4:0]  sel_a = '0, sel_b = '0, sel_c = '0;
    logic [31:0] mem_a [128];
    logic [31:0] mem_b [128];
    logic [31:0] mem_c [128];

    assign rd_a = mem_a[ra_a[8:2]];
    assign rd_b = mem_b[ra_b[8:2]];
    assign rd_c = mem_c[ra_c[8:2]];

    rv32_core dut_a (
        .clk(clk), .rst(rst_a), .read_data(rd_a), .read_address(ra_a), .write_mem(wm_a),
        .funct3(f3_a), .write_address(wa_a), .write_data(wd_a), .halted(h_a),
        .dbg_sel(sel_a), .dbg_data(dd_a)
    );
    rv32_core #(.RESET_PC(32'h40), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst_b), .read_data(rd_b), .read_address(ra_b), .write_mem(wm_b),
        .funct3(f3_b), .write_address(wa_b), .write_data(wd_b), .halted(h_b),
        .dbg_sel(sel_b), .dbg_data(dd_b)
    );
    rv32_core #(.NUM_REGS(16)) dut_c (
        .clk(clk), .rst(rst_c), .read_data(rd_c), .read_address(ra_c), .write_mem(wm_c),
        .funct3(f3_c), .write_address(wa_c), .write_data(wd_c), .halted(h_c),
        .dbg_sel(sel_c), .dbg_data(dd_c)
    );

    int          checks = 0, errors = 0;
    int          st_n = 0;
    logic [31:0] st_a = '0, st_d = '0;
    logic [2:0]  st_f = '0;

    always @(posedge clk) begin
        if (wm_a) begin
            st_n <= st_n + 1;
            st_a <= wa_a;
            st_d <= wd_a;
            st_f <= f3_a;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          cyc;
        logic [4:0]  sel;
        logic [31:0] exp;
        logic [31:0] npc;
    } vec_t;

    vec_t v [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{32'h000, 32'h00500093, 2, 5'd1,  32'h0000_0005, 32'h004};
        v[1]  = '{32'h004, 32'hFF908113, 2, 5'd2,  32'hFFFF_FFFE, 32'h008};
        v[2]  = '{32'h008, 32'h00202423, 2, 5'd2,  32'hFFFF_FFFE, 32'h00C};
        v[3]  = '{32'h00C, 32'h08000183, 3, 5'd3,  32'hFFFF_FFF0, 32'h010};
        v[4]  = '{32'h010, 32'h08004183, 3, 5'd3,  32'h0000_00F0, 32'h014};
        v[5]  = '{32'h014, 32'h123452B7, 2, 5'd5,  32'h1234_5000, 32'h018};
        v[6]  = '{32'h018, 32'h10300293, 2, 5'd5,  32'h0000_0103, 32'h01C};
        v[7]  = '{32'h01C, 32'hFFF13313, 2, 5'd6,  32'h0000_0001, 32'h020};
        v[8]  = '{32'h020, 32'h000280E7, 2, 5'd1,  32'h0000_0024, 32'h102};
        v[9]  = '{32'h102, 32'hFE001CE3, 2, 5'd1,  32'h0000_0024, 32'h106};
        v[10] = '{32'h106, 32'h00000463, 2, 5'd7,  32'h0000_0000, 32'h10E};
        v[11] = '{32'h10E, 32'h401283B3, 2, 5'd7,  32'h0000_00DF, 32'h112};
        v[12] = '{32'h112, 32'h40115413, 2, 5'd8,  32'hFFFF_FFFF, 32'h116};
        v[13] = '{32'h116, 32'h00429493, 2, 5'd9,  32'h0000_1030, 32'h11A};
        v[14] = '{32'h11A, 32'h00001517, 2, 5'd10, 32'h0000_111A, 32'h11E};
        v[15] = '{32'h11E, 32'h008005EF, 2, 5'd11, 32'h0000_0122, 32'h126};
        v[16] = '{32'h126, 32'h00012633, 2, 5'd12, 32'h0000_0001, 32'h12A};
        v[17] = '{32'h12A, 32'h00500013, 2, 5'd0,  32'h0000_0000, 32'h12E};
        v[18] = '{32'h12E, 32'h00000FFF, 2, 5'd31, 32'h0000_0000, 32'h132};
        v[19] = '{32'h132, 32'h08801683, 3, 5'd13, 32'hFFFF_8001, 32'h136};
        v[20] = '{32'h136, 32'h08802703, 3, 5'd14, 32'h0000_8001, 32'h13A};
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            mem_c[i] = '0;
        end
        for (int i = 0; i < 21; i++) mem_a[v[i].addr[8:2]] = v[i].instr;
        mem_a[66] = 32'h00100393;
        mem_a[72] = 32'h00100393;
        mem_a[32] = 32'h0000_00F0;
        mem_a[34] = 32'h0000_8001;
        mem_b[16] = 32'h08000183;
        mem_b[17] = 32'h08004183;
        mem_b[18] = 32'h00500093;
        mem_b[32] = 32'h0000_00F0;
        mem_c[0]  = 32'h00500093;
        mem_c[1]  = 32'h00100A13;

        tick(2);
        chk("rst ra", ra_a, 32'h0);
        chk("rst wm", {31'b0, wm_a}, 32'h0);
        chk("rst f3", {29'b0, f3_a}, 32'h2);
        chk("rst wa", wa_a, 32'h0);
        chk("rst wd", wd_a, 32'h0);
        chk("rst halted", {31'b0, h_a}, 32'h0);
        chk("rst ra_b", ra_b, 32'h40);
        rst_a = 1'b0;

        for (int i = 0; i < 21; i++) begin
            sel_a = v[i].sel;
            tick(v[i].cyc);
            chk($sformatf("row%0d x%0d", i, v[i].sel), dd_a, v[i].exp);
            chk($sformatf("row%0d pc", i), ra_a, v[i].npc);
        end
        chk("store count", st_n, 1);
        chk("store addr", st_a, 32'h8);
        chk("store data", st_d, 32'hFFFF_FFFE);
        chk("store f3", {29'b0, st_f}, 32'h2);

        tick(1);
        chk("halted", {31'b0, h_a}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk($sformatf("halt ra c%0d", i), ra_a, 32'h13A);
        end
        chk("halt wm", {31'b0, wm_a}, 32'h0);
        chk("halt still", {31'b0, h_a}, 32'h1);
        rst_a = 1'b1;
        sel_a = 5'd1;
        tick(1);
        chk("rerst ra", ra_a, 32'h0);
        chk("rerst halted", {31'b0, h_a}, 32'h0);
        chk("rerst x1", dd_a, 32'h0);
        rst_a = 1'b0;

        sel_a = 5'd2;
        tick(4);
        chk("abort pre x2", dd_a, 32'hFFFF_FFFE);
        tick(1);
        chk("abort wm on", {31'b0, wm_a}, 32'h1);
        chk("abort wa on", wa_a, 32'h8);
        chk("abort f3 on", {29'b0, f3_a}, 32'h2);
        rst_a = 1'b1;
        tick(1);
        chk("abort wm off", {31'b0, wm_a}, 32'h0);
        chk("abort wa off", wa_a, 32'h0);
        chk("abort wd off", wd_a, 32'h0);
        chk("abort x2", dd_a, 32'h0);

        sel_b = 5'd3;
        rst_b = 1'b0;
        tick(4);
        chk("lat3 ld ra", ra_b, 32'h80);
        chk("lat3 ld f3", {29'b0, f3_b}, 32'h0);
        tick(2);
        chk("lat3 lb c6", dd_b, 32'h0);
        chk("lat3 lb c6 ra", ra_b, 32'h80);
        tick(1);
        chk("lat3 lb c7", dd_b, 32'hFFFF_FFF0);
        chk("lat3 lb pc", ra_b, 32'h44);
        tick(6);
        chk("lat3 lbu c6", dd_b, 32'hFFFF_FFF0);
        tick(1);
        chk("lat3 lbu c7", dd_b, 32'h0000_00F0);
        chk("lat3 lbu pc", ra_b, 32'h48);
        sel_b = 5'd1;
        tick(3);
        chk("lat3 addi c3", dd_b, 32'h0);
        tick(1);
        chk("lat3 addi c4", dd_b, 32'h5);
        chk("lat3 addi pc", ra_b, 32'h4C);
        tick(3);
        chk("lat3 halted", {31'b0, h_b}, 32'h1);

        rst_c = 1'b0;
        tick(5);
        chk("rv32e halted", {31'b0, h_c}, 32'h1);
        for (int i = 0; i < 32; i++) begin
            sel_c = 5'(i);
            #1;
            chk($sformatf("rv32e x%0d", i), dd_c, i == 1 ? 32'h5 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
